// File: rtl/ntt_arb_pkg.sv
//------------------------------------------------------------------------------
// Module   : ntt_arb_pkg
// Purpose  : Shared types and default constants for the NTT job arbiter.
//            Holds the arbiter state encoding and the default sizing values
//            used by ntt_job_arbiter and ntt_rr_pick.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package ntt_arb_pkg;

    localparam int NTT_ARB_NUM_REQ  = 4;
    localparam int NTT_ARB_COOLDOWN = 2;
    localparam int NTT_ARB_TIMEOUT  = 4096;

    typedef enum logic [1:0] {
        A_IDLE   = 2'd0,
        A_LAUNCH = 2'd1,
        A_WAIT   = 2'd2,
        A_COOL   = 2'd3
    } arb_state_t;

endpackage : ntt_arb_pkg

`default_nettype wire

// File: rtl/ntt_rr_pick.sv
//------------------------------------------------------------------------------
// Module   : ntt_rr_pick
// Purpose  : Combinational round-robin picker. Rotates the request vector so
//            that index i_rr_ptr lands at bit 0, selects the lowest set bit,
//            then maps that position back to an absolute requester index.
// Ports    : i_req     - request vector (one bit per requester)
//            i_rr_ptr  - highest-priority index, must be < NUM_REQ
//            o_any     - at least one request is present
//            o_winner  - index of the selected requester (valid with o_any)
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ntt_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [ID_W-1:0]    i_rr_ptr,
    output logic               o_any,
    output logic [ID_W-1:0]    o_winner
);

    logic [NUM_REQ-1:0] w_rot;
    logic [ID_W-1:0]    w_pos;
    logic [ID_W:0]      w_sum;
    logic [ID_W:0]      w_wrapped;

    // Doubling the vector turns the rotate into a plain right shift.
    assign w_rot = NUM_REQ'({i_req, i_req} >> i_rr_ptr);

    always_comb begin
        w_pos = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_pos = ID_W'(i);
            end
        end
    end

    // Both operands are below NUM_REQ, so one conditional subtract suffices
    // and no power-of-two NUM_REQ is assumed.
    assign w_sum     = {1'b0, w_pos} + {1'b0, i_rr_ptr};
    assign w_wrapped = (w_sum >= (ID_W+1)'(NUM_REQ)) ? (w_sum - (ID_W+1)'(NUM_REQ)) : w_sum;

    assign o_any    = |i_req;
    assign o_winner = w_wrapped[ID_W-1:0];

endmodule : ntt_rr_pick

`default_nettype wire

// File: rtl/ntt_job_arbiter.sv
//------------------------------------------------------------------------------
// Module   : ntt_job_arbiter
// Purpose  : Shares one NTT fold engine between NUM_REQ job requesters in
//            round-robin order. Launches the engine with a one-cycle start
//            pulse, tracks the owner, returns a one-cycle completion pulse to
//            that owner and then idles for a fixed COOLDOWN period so grant
//            timing is independent of data and history.
// Ports    : clk_core, rst          - clock, synchronous active-high reset
//            req_valid/req_inverse  - per-requester request and mode
//            req_ready              - one-hot acceptance pulse
//            cmp_valid/cmp_err      - one-hot completion pulse, watchdog flag
//            eng_start/eng_inverse  - engine launch pulse and latched mode
//            eng_busy/eng_done      - engine status
//            owner/owner_valid      - current owner index, valid LAUNCH/WAIT
//            busy                   - arbiter not idle
//            err_timeout            - sticky watchdog flag
// Options  : NTT_ARB_WATCHDOG_EN - when defined, a WAIT-state watchdog ends a
//            job after TIMEOUT_CYC cycles without eng_done (cmp_err = 1).
//            When undefined, cmp_err and err_timeout are tied to 0.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ntt_job_arbiter
    import ntt_arb_pkg::*;
#(
    parameter int NUM_REQ     = NTT_ARB_NUM_REQ,
    parameter int ID_W        = $clog2(NUM_REQ),
    parameter int COOLDOWN    = NTT_ARB_COOLDOWN,
    parameter int TIMEOUT_CYC = NTT_ARB_TIMEOUT
) (
    input  logic               clk_core,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [NUM_REQ-1:0] req_inverse,
    output logic [NUM_REQ-1:0] req_ready,
    output logic [NUM_REQ-1:0] cmp_valid,
    output logic               cmp_err,
    output logic               eng_start,
    output logic               eng_inverse,
    input  logic               eng_busy,
    input  logic               eng_done,
    output logic [ID_W-1:0]    owner,
    output logic               owner_valid,
    output logic               busy,
    output logic               err_timeout
);

    localparam int COOL_W = 4;

    arb_state_t         r_state;
    logic [ID_W-1:0]    r_rr_ptr;
    logic [ID_W-1:0]    r_owner;
    logic [COOL_W-1:0]  r_cool_cnt;
    logic [NUM_REQ-1:0] r_req_ready;
    logic [NUM_REQ-1:0] r_cmp_valid;
    logic               r_eng_start;
    logic               r_eng_inverse;
    logic               r_owner_valid;
    logic               r_busy;

    logic               w_any;
    logic [ID_W-1:0]    w_winner;
    logic [ID_W:0]      w_ptr_inc;
    logic [ID_W:0]      w_ptr_next;
    logic               w_timeout;

    ntt_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .i_req    (req_valid),
        .i_rr_ptr (r_rr_ptr),
        .o_any    (w_any),
        .o_winner (w_winner)
    );

    // Next priority pointer: the slot after the finishing owner, so that
    // owner drops to lowest priority in the next arbitration.
    assign w_ptr_inc  = {1'b0, r_owner} + (ID_W+1)'(1);
    assign w_ptr_next = (w_ptr_inc >= (ID_W+1)'(NUM_REQ)) ? (w_ptr_inc - (ID_W+1)'(NUM_REQ)) : w_ptr_inc;

`ifdef NTT_ARB_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

    logic [WD_W-1:0] r_wd_cnt;
    logic            r_cmp_err;
    logic            r_err_timeout;

    // Fires on the last of TIMEOUT_CYC WAIT cycles; eng_done in that same
    // cycle takes precedence in the state machine below.
    assign w_timeout   = (r_wd_cnt == WD_W'(TIMEOUT_CYC - 1));
    assign cmp_err     = r_cmp_err;
    assign err_timeout = r_err_timeout;
`else
    logic w_unused_timeout;

    assign w_unused_timeout = ^TIMEOUT_CYC;
    assign w_timeout        = 1'b0;
    assign cmp_err          = 1'b0;
    assign err_timeout      = 1'b0;
`endif

    always_ff @(posedge clk_core) begin
        if (rst) begin
            r_state       <= A_IDLE;
            r_rr_ptr      <= '0;
            r_owner       <= '0;
            r_cool_cnt    <= '0;
            r_req_ready   <= '0;
            r_cmp_valid   <= '0;
            r_eng_start   <= 1'b0;
            r_eng_inverse <= 1'b0;
            r_owner_valid <= 1'b0;
            r_busy        <= 1'b0;
`ifdef NTT_ARB_WATCHDOG_EN
            r_wd_cnt      <= '0;
            r_cmp_err     <= 1'b0;
            r_err_timeout <= 1'b0;
`endif
        end else begin
            // Pulse outputs default low; they are raised for one cycle only.
            r_req_ready <= '0;
            r_cmp_valid <= '0;
            r_eng_start <= 1'b0;
`ifdef NTT_ARB_WATCHDOG_EN
            r_cmp_err   <= 1'b0;
`endif
            case (r_state)
                A_IDLE: begin
                    if (w_any && !eng_busy) begin
                        r_state       <= A_LAUNCH;
                        r_owner       <= w_winner;
                        r_eng_inverse <= req_inverse[w_winner];
                        r_req_ready   <= NUM_REQ'(1) << w_winner;
                        r_eng_start   <= 1'b1;
                        r_owner_valid <= 1'b1;
                        r_busy        <= 1'b1;
                    end
                end

                A_LAUNCH: begin
                    r_state <= A_WAIT;
`ifdef NTT_ARB_WATCHDOG_EN
                    r_wd_cnt <= '0;
`endif
                end

                A_WAIT: begin
                    if (eng_done || w_timeout) begin
                        r_state       <= A_COOL;
                        r_cmp_valid   <= NUM_REQ'(1) << r_owner;
                        r_rr_ptr      <= w_ptr_next[ID_W-1:0];
                        r_owner_valid <= 1'b0;
                        r_cool_cnt    <= COOL_W'(COOLDOWN - 1);
`ifdef NTT_ARB_WATCHDOG_EN
                        r_cmp_err     <= !eng_done;
                        if (!eng_done) begin
                            r_err_timeout <= 1'b1;
                        end
`endif
                    end
`ifdef NTT_ARB_WATCHDOG_EN
                    else begin
                        r_wd_cnt <= r_wd_cnt + WD_W'(1);
                    end
`endif
                end

                A_COOL: begin
                    if (r_cool_cnt == '0) begin
                        r_state <= A_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cool_cnt <= r_cool_cnt - COOL_W'(1);
                    end
                end

                default: begin
                    r_state <= A_IDLE;
                end
            endcase
        end
    end

    assign req_ready   = r_req_ready;
    assign cmp_valid   = r_cmp_valid;
    assign eng_start   = r_eng_start;
    assign eng_inverse = r_eng_inverse;
    assign owner       = r_owner;
    assign owner_valid = r_owner_valid;
    assign busy        = r_busy;

endmodule : ntt_job_arbiter

`default_nettype wire

// File: doc/ntt_job_arbiter.md
Name: ntt_job_arbiter

Overview:
- Shares one NTT fold engine (8-stage, N=256) between NUM_REQ polynomial-job requesters using a fixed round-robin order.
- Launches the engine with a single start pulse, tracks the owning requester, and returns a completion pulse to that owner.
- Enforces a fixed cooldown between jobs so that grant timing does not depend on data or on history.
- Sits between the PQC job queues and the engine's start/busy/done handshake.

Parameters:
- NUM_REQ, 4: number of requesters; legal range 2..16.
- ID_W, $clog2(NUM_REQ): width of the owner index.
- COOLDOWN, 2: idle cycles after each job completes; legal range 1..15.
- TIMEOUT_CYC, 4096: watchdog limit in WAIT cycles; used only when the optional feature is compiled in.

Ports:
- clk_core  in  1  core clock; all logic on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- req_valid  in  NUM_REQ  per-requester job request.
- req_inverse  in  NUM_REQ  per-requester mode: 1 = inverse NTT.
- req_ready  out  NUM_REQ  one-hot, one-cycle acceptance pulse.
- cmp_valid  out  NUM_REQ  one-hot, one-cycle completion pulse to the owner.
- cmp_err  out  1  completion ended by watchdog; qualified by any cmp_valid bit.
- eng_start  out  1  one-cycle engine start pulse.
- eng_inverse  out  1  mode latched at grant; held stable through WAIT.
- eng_busy  in  1  engine busy.
- eng_done  in  1  engine done pulse.
- owner  out  ID_W  index of the current owner.
- owner_valid  out  1  high in LAUNCH and WAIT.
- busy  out  1  high whenever state is not A_IDLE.
- err_timeout  out  1  sticky watchdog flag.

Behaviour:
- Clock and reset: one clock, clk_core. rst is synchronous and active-high.
- Reset values: every output is 0. State = A_IDLE, rr_ptr = 0, cooldown counter = 0, watchdog counter = 0.
- Reset mid-operation: rst wins in any state. The engine is not reset by this block. An eng_done arriving after reset is ignored.
- All outputs are registered.
- States: A_IDLE, A_LAUNCH, A_WAIT, A_COOL.
- A_IDLE grant rule: a grant happens only when req_valid != 0 and eng_busy == 0.
  - Winner = first set bit at index rr_ptr, rr_ptr+1, ... with modulo-NUM_REQ wrap.
  - With eng_busy high (e.g. engine still running after our reset), no grant and no req_ready.
- Grant cycle T (in A_IDLE): next state is A_LAUNCH, owner <= winner, eng_inverse <= req_inverse[winner].
- Cycle T+1 (A_LAUNCH): req_ready[owner] = 1 and eng_start = 1, both for exactly one cycle. Next state is A_WAIT.
- Requester handshake: a requester holds req_valid until it sees req_ready.
  - Dropping req_valid before the grant withdraws the request with no side effect.
  - req_valid still high in the cycle of req_ready is treated as a new request.
- A_WAIT: eng_done sampled at cycle D gives, at D+1:
  - cmp_valid[owner] = 1 for one cycle, cmp_err = 0;
  - rr_ptr <= (owner + 1) mod NUM_REQ;
  - owner_valid = 0;
  - state = A_COOL.
- eng_done in A_IDLE, A_LAUNCH or A_COOL: ignored.
- A_COOL: stays exactly COOLDOWN cycles, then A_IDLE. Requests are not sampled in A_COOL.
- Minimum job-to-job spacing: 1 + 1 + engine latency + COOLDOWN cycles.
- rr_ptr arithmetic: computed in ID_W+1 bits, wrapped by compare-subtract. No reliance on power-of-two NUM_REQ.
- Owner fairness: the owner of the last completed job has the lowest priority in the next arbitration.

Optional Feature:
- Macro: NTT_ARB_WATCHDOG_EN.
- With the macro defined:
  - A counter clears on entry to A_WAIT and increments each A_WAIT cycle.
  - When it reaches TIMEOUT_CYC with no eng_done, the next cycle behaves as a completion with cmp_valid[owner] = 1, cmp_err = 1 and err_timeout set.
  - err_timeout is sticky; only rst clears it.
  - eng_done in the same cycle as the timeout counts as a normal completion (done wins).
- Without the macro:
  - No counter is present.
  - cmp_err and err_timeout are tied to 0.
  - A_WAIT lasts indefinitely until eng_done.

Decomposition:
- Shared package ntt_arb_pkg holds:
  - the arb_state_t enum;
  - default constants: NTT_ARB_NUM_REQ = 4, NTT_ARB_COOLDOWN = 2, NTT_ARB_TIMEOUT = 4096.
- One sub-module is natural: ntt_rr_pick, a combinational rotate/priority/unrotate picker.
  - Inputs: req vector and rr_ptr.
  - Outputs: any, winner index.

Test Plan:
- Single request: req_valid = 4'b0100 in A_IDLE at T → at T+1 req_ready = 4'b0100, eng_start = 1, owner = 2; eng_done at D → cmp_valid = 4'b0100 at D+1; busy = 0 at D+1+COOLDOWN (D+3).
- Contention: all four req_valid held high, re-raised after each ack → grants in order 0,1,2,3,0. No requester is granted twice before the others; spacing is constant when engine latency is fixed.
- Engine still busy: eng_busy = 1 after rst with req_valid = 4'b0001 → no req_ready until eng_busy falls; grant on the following cycle.
- Reset mid-job: rst in A_WAIT at cycle 100 → cycle 101 shows all outputs 0 and rr_ptr = 0; a later eng_done produces no cmp_valid.
- Watchdog: compile with NTT_ARB_WATCHDOG_EN, TIMEOUT_CYC = 16, eng_done never sent → 16 WAIT cycles, then cmp_valid[owner] = 1 and cmp_err = 1; err_timeout stays 1 until rst. Without the macro, busy stays 1.
- Withdrawal and simultaneous events: req_valid[1] dropped before its grant → never acked. Also check eng_done and timeout in the same cycle gives cmp_err = 0.
